// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch button front end.
// Default timings assume a 50 MHz clock.
package stopwatch_pkg;

    // 10 ms of stable input at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    // 1 s clear-button hold at 50 MHz
    localparam int unsigned LONG_PRESS_CYCLES_DEFAULT = 50000000;

    // Bits needed to count 0..n (saturating long-press counter)
    function automatic int sat_width(int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button inputs and conditioned control outputs of the stopwatch front end.
// master drives the raw buttons, slave is the conditioner.
interface button_conditioner_if;

    logic start_stop_button;
    logic clear_button;
    logic hold_count;
    logic counter_reset;
    logic start_stop_level;
    logic clear_level;

    modport master (
        output start_stop_button,
        output clear_button,
        input  hold_count,
        input  counter_reset,
        input  start_stop_level,
        input  clear_level
    );

    modport slave (
        input  start_stop_button,
        input  clear_button,
        output hold_count,
        output counter_reset,
        output start_stop_level,
        output clear_level
    );

endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// level_out follows raw_in after DEBOUNCE_CYCLES consecutive stable cycles.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic level_out
);

    localparam int W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sync_a;
    logic         sync_b;
    logic [W-1:0] count;

    // bring the asynchronous button into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // count mismatched cycles; accept the new level on the last one
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            level_out <= 1'b0;
        end else if (sync_b == level_out) begin
            count <= '0;
        end else if (count == LAST) begin
            count     <= '0;
            level_out <= sync_b;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch start/stop and clear control from two bouncing push-buttons.
// Define STOPWATCH_LONG_PRESS_EN to make clear require a long press.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long_press
        $error("LONG_PRESS_CYCLES must be at least 2");
    end

    logic ss_level;
    logic clr_level;
    logic ss_prev;
    logic ss_rise;
    logic clear_event;
    logic hold;
    logic creset;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_stop (
        .clock    (clock),
        .reset    (reset),
        .raw_in   (bus.start_stop_button),
        .level_out(ss_level)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clock    (clock),
        .reset    (reset),
        .raw_in   (bus.clear_button),
        .level_out(clr_level)
    );

    // remember last start/stop level for press detection
    always_ff @(posedge clock) begin
        if (reset) ss_prev <= 1'b0;
        else       ss_prev <= ss_level;
    end

    assign ss_rise = ss_level & ~ss_prev;

`ifdef STOPWATCH_LONG_PRESS_EN
    localparam int LW = sat_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LP_SAT  = LW'(LONG_PRESS_CYCLES);

    logic [LW-1:0] press_count;

    // saturating hold timer, so the event fires once per press
    always_ff @(posedge clock) begin
        if (reset || !clr_level) press_count <= '0;
        else if (press_count != LP_SAT) press_count <= press_count + 1'b1;
    end

    assign clear_event = clr_level && (press_count == LP_LAST);
`else
    logic clr_prev;

    // remember last clear level for press detection
    always_ff @(posedge clock) begin
        if (reset) clr_prev <= 1'b0;
        else       clr_prev <= clr_level;
    end

    assign clear_event = clr_level & ~clr_prev;
`endif

    // clear pauses and zeroes the counter and beats a same-cycle toggle
    always_ff @(posedge clock) begin
        if (reset) begin
            hold   <= 1'b1;
            creset <= 1'b0;
        end else begin
            creset <= clear_event;
            if (clear_event) hold <= 1'b1;
            else if (ss_rise) hold <= ~hold;
        end
    end

    assign bus.hold_count       = hold;
    assign bus.counter_reset    = creset;
    assign bus.start_stop_level = ss_level;
    assign bus.clear_level      = clr_level;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz); legal range is 2 or more.
REQ-002 Parameter LONG_PRESS_CYCLES, default 50000000, clear-button hold time in cycles, used only under STOPWATCH_LONG_PRESS_EN; legal range is 2 or more.
REQ-003 clock  input  1  the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_stop_button  input  1  raw, asynchronous, bouncing push-button (1 = pressed).
REQ-006 clear_button  input  1  raw, asynchronous, bouncing push-button (1 = pressed).
REQ-007 hold_count  output  1  drives the time counter's hold input; 1 = paused, 0 = counting.
REQ-008 counter_reset  output  1  one-cycle active-high pulse that clears the time counter.
REQ-009 start_stop_level  output  1  debounced level of start_stop_button.
REQ-010 clear_level  output  1  debounced level of clear_button.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 The debouncer SHALL increment its counter each cycle the synchronized input differs from the debounced level, and clear the counter in any cycle where they match.
REQ-013 When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced level SHALL take the synchronized value and the counter SHALL return to 0.
REQ-014 A clean raw change SHALL appear on the *_level output DEBOUNCE_CYCLES+2 rising edges later.
REQ-015 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the *_level output unchanged.
REQ-016 A rising edge of start_stop_level SHALL toggle hold_count one edge after the level rises; release SHALL have no effect.
REQ-017 A clear event SHALL pulse counter_reset high for exactly one cycle and set hold_count to 1 in that same edge.
REQ-018 If a clear event and a start/stop rising edge occur in the same cycle, the clear SHALL win: hold_count = 1 and counter_reset = 1.
REQ-019 The debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES) and SHALL never wrap.
REQ-020 The long-press counter SHALL saturate and SHALL never wrap.
REQ-021 Holding start_stop_button down indefinitely SHALL produce exactly one toggle.

Reset
REQ-022 While reset is high at an edge, all state SHALL take its reset value: synchronizers 0, debounce and long-press counters 0, start_stop_level 0, clear_level 0, hold_count 1, counter_reset 0.
REQ-023 Reset asserted mid-debounce or mid-long-press SHALL discard partial counts.
REQ-024 After reset deasserts, a button already held down SHALL be detected as a new press once debounced.

Configuration
REQ-025 With STOPWATCH_LONG_PRESS_EN defined, a clear event is clear_level continuously high for LONG_PRESS_CYCLES cycles; it SHALL fire once per press, and release before then SHALL produce no pulse.
REQ-026 With STOPWATCH_LONG_PRESS_EN not defined, a clear event is the rising edge of clear_level; no long-press counter SHALL be synthesized.

Structure
REQ-027 The default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants SHALL live in the shared package stopwatch_pkg.
REQ-028 Synchronizer plus debounce SHALL be one sub-module, button_debouncer (ports clock, reset, raw_in, level_out), instantiated twice.
REQ-029 Edge detection, toggle and clear logic SHALL reside in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8)
REQ-030 Reset, then idle: hold_count = 1, counter_reset = 0, both *_level outputs = 0.
REQ-031 start_stop_button goes 0->1 cleanly and stays high: start_stop_level rises 6 edges later and hold_count goes to 0 at edge 7; a second full press returns hold_count to 1.
REQ-032 start_stop_button bounces with 3-cycle pulses before settling high: exactly one toggle, 6 edges after the final settle.
REQ-033 Clear pressed while counting (hold_count = 0), without macro: counter_reset is high for 1 cycle and hold_count = 1; with macro, a hold of 7 post-debounce cycles gives no pulse and a hold of 8 gives one pulse.
REQ-034 Clear event and start/stop edge forced into the same cycle: counter_reset = 1 and hold_count = 1.
REQ-035 Reset asserted 2 cycles into a debounce: level stays 0; with the button still held after reset deasserts, level rises 6 edges later.
